// File: rtl/zip_mem_pkg.sv
// Shared definitions for the ZipCPU Wishbone memory units: op encodings,
// the single-transaction FSM state type, byte-select constants and lane payload.
package zip_mem_pkg;

  localparam logic [1:0] OP_WORD = 2'b01;
  localparam logic [1:0] OP_HALF = 2'b10;
  localparam logic [1:0] OP_BYTE = 2'b11;

  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_BYTE    = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sel;
  } wb_lane_t;

endpackage

// File: rtl/zip_wbmem_lanes.sv
// Big-endian byte-lane steering: positions store data/selects on the bus and
// extracts a zero-extended byte/halfword/word from returned read data.
module zip_wbmem_lanes
  import zip_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_rdata,
  output wb_lane_t    st_lane_c,
  output logic [31:0] ld_data_c
);

  // Store side: replicate narrow data across lanes, select only the target bytes
  always_comb begin
    st_lane_c.data = st_wdata;
    st_lane_c.sel  = SEL_WORD;
    case (st_size)
      OP_BYTE: begin
        st_lane_c.data = {4{st_wdata[7:0]}};
        st_lane_c.sel  = SEL_BYTE >> st_addr;
      end
      OP_HALF: begin
        st_lane_c.data = {2{st_wdata[15:0]}};
        st_lane_c.sel  = st_addr[1] ? SEL_HALF_LO : SEL_HALF_HI;
      end
      default: ;
    endcase
  end

  // Load side: byte 0 lives in the most significant lane
  always_comb begin
    ld_data_c = ld_rdata;
    case (ld_size)
      OP_BYTE: ld_data_c = {24'h0, 8'(ld_rdata >> {~ld_addr, 3'b000})};
      OP_HALF: ld_data_c = {16'h0, ld_addr[1] ? ld_rdata[15:0] : ld_rdata[31:16]};
      default: ;
    endcase
  end

endmodule

// File: rtl/zip_wbmem_single.sv
// Single-outstanding Wishbone memory unit for the ZipCPU: one load/store per bus cycle.
// Define ZIP_WBMEM_LOCK_EN to hold cyc across locked (atomic) request sequences.
module zip_wbmem_single
  import zip_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH     = 30,
  parameter bit          OPT_ALIGNMENT_ERR = 1'b1,
  parameter bit          OPT_ZERO_ON_IDLE  = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stb,
  input  logic                     i_lock,
  input  logic [2:0]               i_op,
  input  logic [ADDRESS_WIDTH+1:0] i_addr,
  input  logic [31:0]              i_data,
  input  logic [4:0]               i_oreg,
  output logic                     o_busy,
  output logic                     o_rdbusy,
  output logic                     o_pipe_stalled,
  output logic                     o_valid,
  output logic                     o_done,
  output logic                     o_err,
  output logic [4:0]               o_wreg,
  output logic [31:0]              o_result,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [31:0]              i_wb_data
);

  localparam int unsigned AW = ADDRESS_WIDTH;

  mem_state_t state_q, state_d;
  logic [1:0] size_q, size_d, alo_q, alo_d;
  logic       lock_q, lock_d, lock_in, misaligned;
  logic       cyc_d, stb_d, we_d, busy_d, rdbusy_d, valid_d, done_d, err_d;
  logic [4:0]    wreg_d;
  logic [31:0]   result_d, data_d, ld_data_c;
  logic [AW-1:0] addr_d;
  logic [3:0]    sel_d;
  wb_lane_t      st_lane_c;

`ifdef ZIP_WBMEM_LOCK_EN
  assign lock_in = i_lock;
`else
  logic unused_lock;
  assign lock_in     = 1'b0;
  assign unused_lock = i_lock;
`endif

  zip_wbmem_lanes u_lanes (
    .st_size  (i_op[2:1]),
    .st_addr  (i_addr[1:0]),
    .st_wdata (i_data),
    .ld_size  (size_q),
    .ld_addr  (alo_q),
    .ld_rdata (i_wb_data),
    .st_lane_c(st_lane_c),
    .ld_data_c(ld_data_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    alo_d    = alo_q;
    lock_d   = lock_q;
    we_d     = o_wb_we;
    wreg_d   = o_wreg;
    result_d = o_result;
    addr_d   = o_wb_addr;
    data_d   = o_wb_data;
    sel_d    = o_wb_sel;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    misaligned = OPT_ALIGNMENT_ERR &&
                 (((i_op[2:1] == OP_HALF) && i_addr[0]) ||
                  ((i_op[2:1] == OP_WORD) && (i_addr[1:0] != 2'b00)));

    case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (i_stb) begin
          if (misaligned) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
            we_d    = i_op[0];
            wreg_d  = i_oreg;
            addr_d  = i_addr[AW+1:2];
            data_d  = st_lane_c.data;
            sel_d   = st_lane_c.sel;
            size_d  = i_op[2:1];
            alo_d   = i_addr[1:0];
            lock_d  = lock_in;
          end
        end else if ((state_q == ST_LOCKED) && !lock_in) begin
          state_d = ST_IDLE;
          lock_d  = 1'b0;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (i_wb_err) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (i_wb_ack) begin
          done_d  = 1'b1;
          valid_d = !o_wb_we;
          if (!o_wb_we)
            result_d = ld_data_c;
          lock_d  = lock_q && lock_in;
          state_d = (lock_q && lock_in) ? ST_LOCKED : ST_IDLE;
        end else if ((state_q == ST_REQ) && !i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cyc_d    = (state_d != ST_IDLE);
    stb_d    = (state_d == ST_REQ);
    busy_d   = (state_d == ST_REQ) || (state_d == ST_WAIT);
    rdbusy_d = busy_d && !we_d;

    if (OPT_ZERO_ON_IDLE && !stb_d) begin
      addr_d = '0;
      data_d = '0;
      sel_d  = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      size_q    <= '0;
      alo_q     <= '0;
      lock_q    <= 1'b0;
      o_busy    <= 1'b0;
      o_rdbusy  <= 1'b0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_wreg    <= '0;
      o_result  <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      alo_q     <= alo_d;
      lock_q    <= lock_d;
      o_busy    <= busy_d;
      o_rdbusy  <= rdbusy_d;
      o_valid   <= valid_d;
      o_done    <= done_d;
      o_err     <= err_d;
      o_wreg    <= wreg_d;
      o_result  <= result_d;
      o_wb_cyc  <= cyc_d;
      o_wb_stb  <= stb_d;
      o_wb_we   <= we_d;
      o_wb_addr <= addr_d;
      o_wb_data <= data_d;
      o_wb_sel  <= sel_d;
    end
  end

  assign o_pipe_stalled = o_busy;

`ifdef FORMAL
  logic [1:0] f_outstanding;
  always_ff @(posedge i_clk) begin
    if (i_reset || !o_wb_cyc)
      f_outstanding <= '0;
    else if (o_wb_stb && !i_wb_stall && !(i_wb_ack || i_wb_err))
      f_outstanding <= f_outstanding + 2'd1;
    else if (!(o_wb_stb && !i_wb_stall) && (i_wb_ack || i_wb_err) && (f_outstanding != 2'd0))
      f_outstanding <= f_outstanding - 2'd1;
  end

  always_comb begin
    assert (f_outstanding <= 2'd1);
    assert (o_busy || !o_rdbusy);
  end
`endif

endmodule

// File: tb/tb_zip_wbmem_single.sv
// Bench for zip_wbmem_single: transaction-level reference model checked every
// cycle, plus directed load/store/error/reset/lock scenarios with literal checks.
module tb_zip_wbmem_single;

  localparam int unsigned AW = 30;
`ifdef ZIP_WBMEM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset, i_stb, i_lock;
  logic [2:0] i_op;
  logic [AW+1:0] i_addr;
  logic [31:0] i_data;
  logic [4:0] i_oreg;
  logic o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_done, o_err;
  logic [4:0] o_wreg;
  logic [31:0] o_result;
  logic o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0] o_wb_sel;
  logic i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  always #5 i_clk = ~i_clk;

  zip_wbmem_single #(
    .ADDRESS_WIDTH(AW), .OPT_ALIGNMENT_ERR(1'b1), .OPT_ZERO_ON_IDLE(1'b0)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_lock(i_lock),
    .i_op(i_op), .i_addr(i_addr), .i_data(i_data), .i_oreg(i_oreg),
    .o_busy(o_busy), .o_rdbusy(o_rdbusy), .o_pipe_stalled(o_pipe_stalled),
    .o_valid(o_valid), .o_done(o_done), .o_err(o_err), .o_wreg(o_wreg),
    .o_result(o_result), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b11) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [1:0] a);
    int n = nbytes(sz);
    int base = int'(a) - (int'(a) % n);
    logic [3:0] m = 4'((1 << n) - 1);
    return 4'(m << (4 - n - base));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_extract(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    int base = int'(a) - (int'(a) % n);
    logic [31:0] v = rd >> (8 * (4 - n - base));
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 64'd1);
    return v & mask;
  endfunction

  bit m_on = 1'b0;
  bit m_have, m_issued, m_locked, m_store, m_lock;
  logic [1:0] m_size, m_alo;
  logic e_valid, e_done, e_err, e_we;
  logic [4:0] e_wreg;
  logic [31:0] e_result, e_data;
  logic [AW-1:0] e_addr;
  logic [3:0] e_sel;

  always @(posedge i_clk) begin
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (i_reset) begin
      m_on = 1'b1; m_have = 1'b0; m_issued = 1'b0; m_locked = 1'b0;
      m_store = 1'b0; m_lock = 1'b0; m_size = '0; m_alo = '0;
      e_we = 1'b0; e_wreg = '0; e_result = '0; e_data = '0; e_addr = '0; e_sel = '0;
    end else if (m_have) begin
      if (i_wb_err) begin
        e_err = 1'b1; m_have = 1'b0; m_locked = 1'b0;
      end else if (i_wb_ack) begin
        e_done = 1'b1;
        if (!m_store) begin
          e_valid = 1'b1;
          e_result = m_extract(m_size, m_alo, i_wb_data);
        end
        m_have = 1'b0;
        m_locked = LOCK_EN && m_lock && i_lock;
      end else if (!m_issued && !i_wb_stall) begin
        m_issued = 1'b1;
      end
    end else if (i_stb) begin
      if (m_misaligned(i_op[2:1], i_addr[1:0])) begin
        e_err = 1'b1; m_locked = 1'b0;
      end else begin
        m_have = 1'b1; m_issued = 1'b0; m_store = i_op[0];
        m_size = i_op[2:1]; m_alo = i_addr[1:0]; m_lock = LOCK_EN && i_lock;
        e_we = i_op[0]; e_wreg = i_oreg; e_addr = i_addr[AW+1:2];
        e_sel = m_sel(i_op[2:1], i_addr[1:0]);
        e_data = m_wdata(i_op[2:1], i_data);
      end
    end else if (m_locked && !i_lock) begin
      m_locked = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (m_on) begin
      check("ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_rdbusy, o_pipe_stalled, o_valid, o_done, o_err}),
            32'({m_have || m_locked, m_have && !m_issued, e_we, m_have, m_have && !m_store, m_have,
                 e_valid, e_done, e_err}));
      check("wb_addr", 32'(o_wb_addr), 32'(e_addr));
      check("wb_data", o_wb_data, e_data);
      check("wb_sel", 32'(o_wb_sel), 32'(e_sel));
      check("result", o_result, e_result);
      check("wreg", 32'(o_wreg), 32'(e_wreg));
    end
  end

  // ---------------- stimulus ----------------
  // Drive a request at the current negedge; return one negedge later (DUT in REQ or err strobe)
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] oreg, input bit lock);
    i_stb = 1'b1; i_op = op; i_addr = addr; i_data = data; i_oreg = oreg; i_lock = lock;
    @(negedge i_clk);
    i_stb = 1'b0;
  endtask

  // Slave: stall n cycles, accept, then ack/err next cycle; returns when strobe is visible
  task automatic respond(input int stalls, input bit err, input logic [31:0] rdata);
    for (int k = 0; k < stalls; k++) begin
      i_wb_stall = 1'b1;
      @(negedge i_clk);
    end
    i_wb_stall = 1'b0;
    @(negedge i_clk);
    i_wb_ack = !err; i_wb_err = err; i_wb_data = rdata;
    @(negedge i_clk);
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_stb = 1'b0; i_lock = 1'b0; i_op = 3'b010; i_addr = '0;
    i_data = '0; i_oreg = '0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    i_wb_data = '0;
    repeat (3) @(negedge i_clk);
    check("reset_cyc", 32'(o_wb_cyc), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // 1: word load, two stall cycles
    issue(3'b010, 32'h1000, 32'h0, 5'd5, 1'b0);
    check("t1_addr", 32'(o_wb_addr), 32'h400);
    check("t1_sel", 32'(o_wb_sel), 32'hF);
    check("t1_rdbusy", 32'(o_rdbusy), 32'd1);
    respond(2, 1'b0, 32'hDEADBEEF);
    check("t1_valid_done", 32'({o_valid, o_done, o_busy}), 32'b110);
    check("t1_result", o_result, 32'hDEADBEEF);
    check("t1_wreg", 32'(o_wreg), 32'd5);
    @(negedge i_clk);

    // 2: byte store to lane 3
    issue(3'b111, 32'h1003, 32'h0000_00A5, 5'd1, 1'b0);
    check("t2_we_sel", 32'({o_wb_we, o_wb_sel}), 32'b1_0001);
    check("t2_data", o_wb_data, 32'hA5A5A5A5);
    check("t2_rdbusy", 32'(o_rdbusy), 32'd0);
    respond(1, 1'b0, 32'h0);
    check("t2_done", 32'({o_valid, o_done}), 32'b01);

    // 3: halfword and byte loads
    issue(3'b100, 32'h2002, 32'h0, 5'd7, 1'b0);
    respond(0, 1'b0, 32'h12345678);
    check("t3_half_lo", o_result, 32'h00005678);
    issue(3'b100, 32'h2000, 32'h0, 5'd8, 1'b0);
    respond(0, 1'b0, 32'h12345678);
    check("t3_half_hi", o_result, 32'h00001234);
    issue(3'b110, 32'h2001, 32'h0, 5'd9, 1'b0);
    respond(1, 1'b0, 32'h12345678);
    check("t3_byte1", o_result, 32'h00000034);
    issue(3'b101, 32'h2002, 32'h0000_BEEF, 5'd2, 1'b0);
    check("t3_hstore_data", o_wb_data, 32'hBEEFBEEF);
    check("t3_hstore_sel", 32'(o_wb_sel), 32'h3);
    respond(0, 1'b0, 32'h0);

    // 4: misaligned word and halfword
    issue(3'b010, 32'h1001, 32'h0, 5'd3, 1'b0);
    check("t4_err", 32'({o_err, o_done, o_wb_cyc}), 32'b100);
    @(negedge i_clk);
    issue(3'b100, 32'h1003, 32'h0, 5'd3, 1'b0);
    check("t4_half_err", 32'({o_err, o_wb_cyc}), 32'b10);
    @(negedge i_clk);

    // 5: bus error, then a normal request, then reset in WAIT
    issue(3'b011, 32'h3000, 32'hCAFEF00D, 5'd4, 1'b0);
    respond(1, 1'b1, 32'h0);
    check("t5_err", 32'({o_err, o_done, o_valid, o_wb_cyc}), 32'b1000);
    @(negedge i_clk);
    check("t5_err_once", 32'(o_err), 32'd0);
    issue(3'b010, 32'h3004, 32'h0, 5'd6, 1'b0);
    respond(0, 1'b0, 32'h01020304);
    check("t5_recover", o_result, 32'h01020304);
    issue(3'b010, 32'h4000, 32'h0, 5'd10, 1'b0);
    @(negedge i_clk);
    check("t5_wait", 32'({o_wb_cyc, o_wb_stb}), 32'b10);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("t5_rst_cyc", 32'(o_wb_cyc), 32'd0);
    i_reset = 1'b0; i_wb_ack = 1'b1; i_wb_data = 32'h55555555;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    check("t5_late_ack", 32'({o_done, o_valid}), 32'b00);
    i_wb_err = 1'b1;
    @(negedge i_clk);
    i_wb_err = 1'b0;
    @(negedge i_clk);
    check("t5_stray_err", 32'(o_err), 32'd0);

    // 6: locked load then store
    issue(3'b010, 32'h5000, 32'h0, 5'd11, 1'b1);
    respond(1, 1'b0, 32'h11112222);
    check("t6_cyc_hold1", 32'(o_wb_cyc), 32'(LOCK_EN));
    issue(3'b011, 32'h5004, 32'h33334444, 5'd12, 1'b1);
    check("t6_cyc_req2", 32'(o_wb_cyc), 32'd1);
    respond(0, 1'b0, 32'h0);
    check("t6_cyc_hold2", 32'(o_wb_cyc), 32'(LOCK_EN));
    i_lock = 1'b0;
    @(negedge i_clk);
    check("t6_release", 32'(o_wb_cyc), 32'd0);

    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
